mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the pipeline and the single-port, byte-wide RAM.
- Arbitrates instruction fetches from the IF stage and load/store requests raised by the MEM stage.
- Splits each access into 1/2/4 little-endian byte transactions, assembles and sign-extends load data, and returns a one-cycle done pulse to the requester.
- The MEM stage's memory request/address/data outputs feed this block; its done/data outputs return to IF, MEM and ctrl.

Parameters:
ADDR_WIDTH, 32, width of all address ports

Ports:
clk  in  1  clock
rst  in  1  reset
rdy_i  in  1  global ready; low freezes the block
if_req_i  in  1  fetch request, held until if_done_o
if_flush_i  in  1  abort pending/active fetch (branch redirect)
if_addr_i  in  ADDR_WIDTH  fetch address
if_data_o  out  32  fetched instruction word
if_done_o  out  1  one-cycle fetch completion pulse
mem_req_i  in  1  load/store request, held until mem_done_o
mem_wr_i  in  1  1=store, 0=load
mem_addr_i  in  ADDR_WIDTH  data address
mem_wdata_i  in  32  store data (low bytes used)
mem_width_i  in  2  0=byte, 1=half, 2=word, 3 treated as word
mem_signed_i  in  1  sign-extend load result
mem_rdata_o  out  32  load result
mem_done_o  out  1  one-cycle load/store completion pulse
busy_o  out  1  high whenever state != IDLE
ram_a_o  out  ADDR_WIDTH  RAM byte address
ram_wr_o  out  1  RAM write enable
ram_dout_o  out  8  RAM write byte
ram_din_i  in  8  RAM read byte, valid one cycle after address

Behaviour:
- Reset: rst is synchronous, active-high. State IDLE, byte counter 0. All outputs 0: if_data_o, mem_rdata_o, dones, busy_o, ram_a_o, ram_wr_o, ram_dout_o.
- Reset mid-operation: abort immediately, no further RAM writes, no done pulse.
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR.
  - IDLE accepts a request only when neither done output is high that cycle; requesters drop req the cycle after done.
  - Priority: mem_req_i beats if_req_i when both are high in IDLE.
  - The accepting edge latches the address, width, signedness and wdata; byte counter k=0.
- Byte count N: IF always 4; MEM 1/2/4 from mem_width_i.
- Read (IF_RD/MEM_RD), request sampled in cycle 0:
  - Cycles 1..N: ram_a_o=addr+k, ram_wr_o=0.
  - ram_din_i in cycle k+2 is byte k, stored at bits [8k+7:8k].
  - Last byte captured at end of cycle N+1; data output updated and done high in cycle N+2.
  - Word load: done in cycle 6.
- Write (MEM_WR):
  - Cycles 1..N: ram_a_o=addr+k, ram_wr_o=1, ram_dout_o=wdata[8k+7:8k].
  - Done in cycle N+1, with ram_wr_o back to 0.
  - ram_wr_o is high exactly N cycles per store.
- Load extension:
  - Byte: signed replicates bit7, else zero-fill.
  - Half: signed replicates bit15, else zero-fill.
  - Word: unchanged.
  - mem_signed_i is ignored for stores and IF.
- Output holding:
  - if_data_o and mem_rdata_o hold their last value until the next completion of the same type.
  - A store leaves mem_rdata_o unchanged.
- Idle outputs: when not actively presenting a byte, ram_a_o=0, ram_wr_o=0, ram_dout_o=0.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No alignment check: misaligned accesses are simply byte-serialised.
- if_flush_i:
  - In IF_RD: return to IDLE next edge, no if_done_o, if_data_o unchanged.
  - In IDLE with only if_req_i: suppresses acceptance.
  - Has no effect on MEM accesses.
- rdy_i low:
  - All state, counters and outputs hold.
  - ram_wr_o forced to 0 combinationally, so no duplicate writes.
  - The RAM stalls on the same signal, so ram_din_i remains valid on resume.
  - Done pulses are delayed by the stall length, never lost or lengthened.
- done pulses are registered and last exactly one enabled cycle. if_done_o and mem_done_o are never high together.

Test Plan:
1. After reset, IF fetch at 0x00000004, RAM[4..7]=13,05,00,00 -> ram_a_o 4,5,6,7 in cycles 1-4; if_data_o=0x00000513 with if_done_o in cycle 6; ram_wr_o stays 0.
2. Loads at 0x1000=0x80: LB signed -> 0xFFFFFF80, LBU -> 0x00000080. LH signed at 0x1002 with bytes 34,92 -> 0xFFFF9234; done in cycle 3 for bytes, cycle 4 for halves.
3. SW 0xDEADBEEF to 0x2000 -> EF,BE,AD,DE written to 0x2000..0x2003 in cycles 1-4, mem_done_o in cycle 5. SB 0x123456AB to 0x2005 -> single write of AB, done cycle 2.
4. if_req_i and mem_req_i (LW 0x3000) high in the same cycle -> LW served first, mem_done_o cycle 6. Fetch accepted after, if_done_o 7 cycles after mem_done_o; no overlap of RAM addresses.
5. if_flush_i asserted in cycle 2 of a fetch -> no if_done_o, busy_o low next cycle. A new fetch to 0x8 is accepted and completes normally.
6. rdy_i low for 3 cycles during SW cycle 2 -> still exactly 4 write cycles, done at cycle 8. rst during cycle 3 of SW -> only bytes 0,1 written, all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF fetches and MEM loads/stores onto a
// single-port byte-wide RAM, assembling little-endian words and extending loads.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy_i,
  input  logic                  if_req_i,
  input  logic                  if_flush_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_wr_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [1:0]            mem_width_i,
  input  logic                  mem_signed_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  // Handshake: a requester raises req with stable address/data and holds it until
  // its done pulse; it drops req the cycle after done, so IDLE ignores requests
  // while either done is high.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IF_RD  = 2'd1;
  localparam logic [1:0] MEM_RD = 2'd2;
  localparam logic [1:0] MEM_WR = 2'd3;

  logic [1:0]            state_q;
  logic [2:0]            cnt_q;
  logic [2:0]            len_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;
  logic [1:0]            width_q;
  logic                  sign_q;

  logic        rd_state;
  logic        presenting;
  logic [31:0] wdata_sh;
  logic [1:0]  byte_idx;
  logic [31:0] next_buf;
  logic [31:0] load_ext;

  function automatic logic [2:0] width_len(input logic [1:0] w);
    case (w)
      2'd0:    width_len = 3'd1;
      2'd1:    width_len = 3'd2;
      default: width_len = 3'd4;
    endcase
  endfunction

  assign rd_state   = (state_q == IF_RD) || (state_q == MEM_RD);
  assign presenting = (rd_state && (cnt_q < len_q)) || (state_q == MEM_WR);
  assign busy_o     = (state_q != IDLE);
  assign wdata_sh   = wdata_q >> {cnt_q[1:0], 3'b000};

  assign ram_a_o    = presenting ? (addr_q + ADDR_WIDTH'(cnt_q)) : '0;
  // Write strobe is gated by stall and reset so a frozen or aborted store never repeats a byte.
  assign ram_wr_o   = (state_q == MEM_WR) && rdy_i && !rst;
  assign ram_dout_o = (state_q == MEM_WR) ? wdata_sh[7:0] : 8'd0;

  // The byte arriving now belongs to the address presented one cycle earlier.
  assign byte_idx = cnt_q[1:0] - 2'd1;

  always_comb begin
    next_buf = buf_q;
    if (cnt_q != 3'd0) next_buf[{byte_idx, 3'b000} +: 8] = ram_din_i;
  end

  always_comb begin
    case (width_q)
      2'd0:    load_ext = {{24{sign_q & next_buf[7]}}, next_buf[7:0]};
      2'd1:    load_ext = {{16{sign_q & next_buf[15]}}, next_buf[15:0]};
      default: load_ext = next_buf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      width_q     <= 2'd0;
      sign_q      <= 1'b0;
      if_data_o   <= 32'd0;
      mem_rdata_o <= 32'd0;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
    end else if (rdy_i) begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!if_done_o && !mem_done_o) begin
            if (mem_req_i) begin
              state_q <= mem_wr_i ? MEM_WR : MEM_RD;
              addr_q  <= mem_addr_i;
              wdata_q <= mem_wdata_i;
              width_q <= mem_width_i;
              sign_q  <= mem_signed_i;
              len_q   <= width_len(mem_width_i);
              cnt_q   <= 3'd0;
              buf_q   <= 32'd0;
            end else if (if_req_i && !if_flush_i) begin
              state_q <= IF_RD;
              addr_q  <= if_addr_i;
              width_q <= 2'd2;
              sign_q  <= 1'b0;
              len_q   <= 3'd4;
              cnt_q   <= 3'd0;
              buf_q   <= 32'd0;
            end
          end
        end
        IF_RD: begin
          if (if_flush_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
          end else begin
            buf_q <= next_buf;
            if (cnt_q == len_q) begin
              if_data_o <= next_buf;
              if_done_o <= 1'b1;
              state_q   <= IDLE;
              cnt_q     <= 3'd0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        MEM_RD: begin
          buf_q <= next_buf;
          if (cnt_q == len_q) begin
            mem_rdata_o <= load_ext;
            mem_done_o  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
          if (cnt_q == len_q - 3'd1) begin
            mem_done_o <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, directed and random loads/stores/fetches,
// scoreboard queues for fetch data, MEM completions and RAM write traffic.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_i;
  logic        if_req_i;
  logic        if_flush_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        mem_req_i;
  logic        mem_wr_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [1:0]  mem_width_i;
  logic        mem_signed_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        busy_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i = 8'd0;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy_i(rdy_i),
    .if_req_i(if_req_i), .if_flush_i(if_flush_i), .if_addr_i(if_addr_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_width_i(mem_width_i), .mem_signed_i(mem_signed_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .busy_o(busy_o),
    .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  // ---------------- clock / cycle counter / RAM model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [0:65535];
  always @(posedge clk) if (rdy_i) ram_din_i <= ram[ram_a_o[15:0]];

  // ---------------- scoreboard ----------------
  logic [31:0] exp_if_q[$];
  logic [32:0] exp_mem_q[$];   // {is_load, data}
  logic [39:0] exp_wr_q[$];    // {addr, byte}
  logic [31:0] last_ld = 32'd0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rdy_i) begin
      logic [32:0] m;
      logic [39:0] w;
      if (if_done_o || mem_done_o) check("done_excl", {31'd0, if_done_o & mem_done_o}, 32'd0);
      if (if_done_o) begin
        if (exp_if_q.size() == 0) check("if_done_unexp", 32'd1, 32'd0);
        else check("if_data", if_data_o, exp_if_q.pop_front());
      end
      if (mem_done_o) begin
        if (exp_mem_q.size() == 0) check("mem_done_unexp", 32'd1, 32'd0);
        else begin
          m = exp_mem_q.pop_front();
          check(m[32] ? "mem_rdata" : "rdata_hold_st", mem_rdata_o, m[31:0]);
        end
      end
      if (ram_wr_o) begin
        n_wr++;
        if (exp_wr_q.size() == 0) check("wr_unexp", ram_a_o, 32'hFFFF_FFFF);
        else begin
          w = exp_wr_q.pop_front();
          check("wr_addr", ram_a_o, w[39:8]);
          check("wr_byte", {24'd0, ram_dout_o}, {24'd0, w[7:0]});
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_ld(input logic [31:0] a, input logic [1:0] w, input bit s);
    logic [31:0] v;
    v = {ram[16'(a + 32'd3)], ram[16'(a + 32'd2)], ram[16'(a + 32'd1)], ram[16'(a)]};
    case (w)
      2'd0:    return s ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
      2'd1:    return s ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic int n_bytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit want_if, input int start, input int exp_lat, input string tag);
    int lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rdy_i && (want_if ? if_done_o : mem_done_o)) begin
        lat = cyc - start;
        break;
      end
    end
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp);
    int start;
    if_req_i = 1'b1; if_addr_i = a; start = cyc;
    exp_if_q.push_back(exp);
    @(negedge clk);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("if_ram_a", ram_a_o, a + 32'(j - 1));
      check("if_ram_wr", {31'd0, ram_wr_o}, 32'd0);
    end
    wait_done(1'b1, start, 6, "if_latency");
    tick();
    if_req_i = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] w, input bit s, input logic [31:0] exp);
    int start;
    int n;
    n = n_bytes(w);
    mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = a; mem_width_i = w; mem_signed_i = s;
    start = cyc;
    exp_mem_q.push_back({1'b1, exp});
    last_ld = exp;
    @(negedge clk);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      check("ld_ram_a", ram_a_o, a + 32'(j - 1));
    end
    wait_done(1'b0, start, n + 2, "ld_latency");
    tick();
    mem_req_i = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    int start;
    int n;
    int wr0;
    n = n_bytes(w);
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = a; mem_width_i = w;
    mem_wdata_i = d; mem_signed_i = $urandom_range(0, 1);
    start = cyc;
    wr0 = n_wr;
    for (int k = 0; k < n; k++) exp_wr_q.push_back({a + 32'(k), d[8*k +: 8]});
    exp_mem_q.push_back({1'b0, last_ld});
    wait_done(1'b0, start, n + 1, "st_latency");
    check("st_wr_count", 32'(n_wr - wr0), 32'(n));
    tick();
    mem_req_i = 1'b0; mem_wr_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int wr0;
    logic [31:0] a;
    logic [1:0]  w;
    bit          s;

    for (int i = 0; i < 65536; i++) ram[i] = 8'd0;
    rst = 1'b1; rdy_i = 1'b1;
    if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = 32'd0;
    mem_req_i = 1'b0; mem_wr_i = 1'b0; mem_addr_i = 32'd0;
    mem_wdata_i = 32'd0; mem_width_i = 2'd0; mem_signed_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_dones", {30'd0, if_done_o, mem_done_o}, 32'd0);
    check("rst_ram_a", ram_a_o, 32'd0);
    check("rst_ram_wr", {23'd0, ram_wr_o, ram_dout_o}, 32'd0);
    check("rst_if_data", if_data_o, 32'd0);
    check("rst_mem_rdata", mem_rdata_o, 32'd0);
    tick();

    // Fetch after reset
    ram[4] = 8'h13; ram[5] = 8'h05; ram[6] = 8'h00; ram[7] = 8'h00;
    do_fetch(32'h4, 32'h0000_0513);

    // Sign/zero-extended loads
    ram[16'h1000] = 8'h80; ram[16'h1001] = 8'h11; ram[16'h1002] = 8'h34; ram[16'h1003] = 8'h92;
    do_load(32'h1000, 2'd0, 1'b1, 32'hFFFF_FF80);
    do_load(32'h1000, 2'd0, 1'b0, 32'h0000_0080);
    do_load(32'h1002, 2'd1, 1'b1, 32'hFFFF_9234);
    do_load(32'h1002, 2'd1, 1'b0, 32'h0000_9234);
    do_load(32'h1000, 2'd2, 1'b1, 32'h9234_1180);

    // Stores
    do_store(32'h2000, 2'd2, 32'hDEAD_BEEF);
    do_store(32'h2005, 2'd0, 32'h1234_56AB);
    do_store(32'h2011, 2'd1, 32'hCAFE_F00D);

    // Simultaneous requests: MEM wins, fetch follows
    ram[16'h3000] = 8'h01; ram[16'h3001] = 8'h02; ram[16'h3002] = 8'h03; ram[16'h3003] = 8'h04;
    ram[16'h0010] = 8'h93; ram[16'h0011] = 8'h00; ram[16'h0012] = 8'h10; ram[16'h0013] = 8'h00;
    mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = 32'h3000; mem_width_i = 2'd2; mem_signed_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h10;
    exp_mem_q.push_back({1'b1, 32'h0403_0201}); last_ld = 32'h0403_0201;
    exp_if_q.push_back(32'h0010_0093);
    start = cyc;
    @(negedge clk);
    @(negedge clk);
    check("arb_first_addr", ram_a_o, 32'h3000);
    wait_done(1'b0, start, 6, "arb_mem_latency");
    tick();
    mem_req_i = 1'b0;
    wait_done(1'b1, start + 6, 7, "arb_if_after_mem");
    tick();
    if_req_i = 1'b0;

    // Flush during a fetch
    if_req_i = 1'b1; if_addr_i = 32'h20;
    tick();
    tick();
    if_flush_i = 1'b1;
    tick();
    if_flush_i = 1'b0; if_req_i = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_if_hold", if_data_o, 32'h0010_0093);
    repeat (6) tick();
    // Flush in IDLE suppresses acceptance
    if_req_i = 1'b1; if_flush_i = 1'b1;
    tick();
    @(negedge clk);
    check("idle_flush_busy", {31'd0, busy_o}, 32'd0);
    tick();
    if_req_i = 1'b0; if_flush_i = 1'b0;
    tick();
    ram[8] = 8'h13; ram[9] = 8'h01; ram[10] = 8'h00; ram[11] = 8'h00;
    do_fetch(32'h8, 32'h0000_0113);

    // Stall three cycles during a word store
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h2100; mem_width_i = 2'd2;
    mem_wdata_i = 32'h1122_3344;
    for (int k = 0; k < 4; k++) exp_wr_q.push_back({32'h2100 + 32'(k), mem_wdata_i[8*k +: 8]});
    exp_mem_q.push_back({1'b0, last_ld});
    start = cyc; wr0 = n_wr;
    tick();
    tick();
    rdy_i = 1'b0;
    @(negedge clk);
    check("stall_wr_low", {31'd0, ram_wr_o}, 32'd0);
    tick();
    tick();
    tick();
    rdy_i = 1'b1;
    wait_done(1'b0, start, 8, "stall_st_latency");
    check("stall_wr_count", 32'(n_wr - wr0), 32'd4);
    tick();
    mem_req_i = 1'b0; mem_wr_i = 1'b0;

    // Reset in cycle 3 of a word store
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h2200; mem_width_i = 2'd2;
    mem_wdata_i = 32'hA1B2_C3D4;
    exp_wr_q.push_back({32'h2200, 8'hD4});
    exp_wr_q.push_back({32'h2201, 8'hC3});
    tick();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wr", {31'd0, ram_wr_o}, 32'd0);
    tick();
    mem_req_i = 1'b0; mem_wr_i = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    check("rst_mid_ram", {ram_a_o[22:0], ram_wr_o, ram_dout_o}, 32'd0);
    check("rst_mid_data", if_data_o | mem_rdata_o, 32'd0);
    check("rst_mid_dones", {30'd0, if_done_o, mem_done_o}, 32'd0);
    tick();
    rst = 1'b0;
    last_ld = 32'd0;
    repeat (2) tick();

    // Random loads and stores
    for (int i = 0; i < 8; i++) begin
      a = 32'h4000 + 32'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) ram[16'(a + 32'(k))] = 8'($urandom_range(0, 255));
      w = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      do_load(a, w, s, model_ld(a, w, s));
      do_store(32'h5000 + 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), $urandom);
    end

    repeat (4) tick();
    check("if_q_left", 32'(exp_if_q.size()), 32'd0);
    check("mem_q_left", 32'(exp_mem_q.size()), 32'd0);
    check("wr_q_left", 32'(exp_wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
